// File: rtl/instr_loader.sv
// Instruction loader: assembles 16-bit words from a byte stream (high byte first)
// and writes them into instruction memory until an END word or the memory fills.
module instr_loader #(
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              prog_done,
  output logic [ADDR_W:0]   instr_count,
  output logic              error
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    HIGH,
    LOW,
    WRITE,
    DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]        hi_reg;
  logic [TMR_W-1:0]  timer;
  logic              xfer;

  assign byte_ready = (state == HIGH) || (state == LOW);
  assign xfer       = byte_valid && byte_ready;

  // The low byte is latched straight into wr_data[7:0], which doubles as lo_reg,
  // so the write strobe can appear the cycle right after the low-byte transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= '0;
      hi_reg      <= '0;
      timer       <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      prog_done   <= 1'b0;
      instr_count <= '0;
      error       <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (load_en) begin
            state       <= HIGH;
            ptr         <= '0;
            timer       <= '0;
            instr_count <= '0;
            error       <= 1'b0;
            prog_done   <= 1'b0;
          end
        end
        HIGH: begin
          if (xfer) begin
            hi_reg <= byte_in;
            state  <= LOW;
          end
        end
        LOW: begin
          if (xfer) begin
            wr_data <= {hi_reg, byte_in};
            wr_addr <= ptr;
            wr_en   <= 1'b1;
            timer   <= '0;
            state   <= WRITE;
          end else if (timer == TMR_LAST) begin
            timer     <= '0;
            error     <= 1'b1;
            prog_done <= 1'b0;
            state     <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WRITE: begin
          instr_count <= instr_count + 1'b1;
          if (wr_data[15:13] == 3'b000) begin
            prog_done <= 1'b1;
            state     <= DONE;
          end else if (ptr == LAST_PTR) begin
            error     <= 1'b1;
            prog_done <= 1'b1;
            state     <= DONE;
          end else begin
            ptr   <= ptr + 1'b1;
            state <= HIGH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: directed table of programs, multi-cycle corner sequences
// and random programs checked against a word-level model of the load rules.
module tb_instr_loader;

  localparam int DEPTH   = 8;
  localparam int ADDR_W  = 3;
  localparam int TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              load_en = 1'b0;
  logic [7:0]        byte_in = 8'h00;
  logic              byte_valid = 1'b0;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              prog_done;
  logic [ADDR_W:0]   instr_count;
  logic              error;

  instr_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .reset(reset),
    .load_en(load_en),
    .byte_in(byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .prog_done(prog_done),
    .instr_count(instr_count),
    .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]        n;
    logic [7:0][15:0]  w;
    logic [3:0]        exp_count;
    logic              exp_err;
    logic              exp_done;
    logic [2:0]        exp_last_addr;
    logic [15:0]       exp_last_data;
  } vec_t;

  vec_t        tbl[4];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          last_xfer_cyc = -10;
  int          last_wr_cyc = -10;
  int          max_gap = 0;
  int          exp_n;
  logic        exp_err;
  logic [18:0] got_q[$];
  logic [15:0] prog_q[$];

  task automatic check_output(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Every write is logged, and must land exactly one cycle after the last byte transfer.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      got_q.push_back({wr_addr, wr_data});
      last_wr_cyc = cyc;
      check_output("wr_latency", cyc, last_xfer_cyc + 1);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    byte_valid = 1'b0;
    repeat (gap) step();
    byte_in    = b;
    byte_valid = 1'b1;
    n = 0;
    while (byte_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (byte_ready === 1'b1) begin
      last_xfer_cyc = cyc;
      step();
    end else begin
      check_output("byte_ready_wait", {31'b0, byte_ready}, 32'd1);
    end
    byte_valid = 1'b0;
  endtask

  task automatic start_load();
    got_q.delete();
    step();
    load_en = 1'b1;
    step();
    load_en = 1'b0;
  endtask

  task automatic apply_stimulus();
    foreach (prog_q[k]) begin
      send_byte(prog_q[k][15:8], $urandom_range(0, max_gap));
      send_byte(prog_q[k][7:0], $urandom_range(0, max_gap));
    end
    step();
    step();
  endtask

  // A load stores words in order from address 0 and stops after the first END
  // word, or after DEPTH words with an error if none of them was END.
  task automatic model_program();
    exp_n   = 0;
    exp_err = 1'b0;
    foreach (prog_q[i]) begin
      exp_n++;
      if (prog_q[i][15:13] == 3'b000) break;
      if (exp_n == DEPTH) begin
        exp_err = 1'b1;
        break;
      end
    end
    while (prog_q.size() > exp_n) void'(prog_q.pop_back());
  endtask

  task automatic check_against_model();
    check_output("n_writes", got_q.size(), exp_n);
    for (int i = 0; i < got_q.size() && i < exp_n; i++) begin
      check_output("wr_addr", {13'b0, got_q[i][18:16]}, i);
      check_output("wr_data", {16'b0, got_q[i][15:0]}, {16'b0, prog_q[i]});
    end
    check_output("instr_count", {27'b0, instr_count}, exp_n);
    check_output("error", {31'b0, error}, {31'b0, exp_err});
    check_output("prog_done", {31'b0, prog_done}, 32'd1);
    check_output("byte_ready_done", {31'b0, byte_ready}, 32'd0);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = tbl[i];
    prog_q.delete();
    for (int k = 0; k < int'(v.n); k++) prog_q.push_back(v.w[k]);
    start_load();
    apply_stimulus();
    check_output("tbl_n_writes", got_q.size(), {28'b0, v.exp_count});
    for (int k = 0; k < got_q.size() && k < int'(v.n); k++) begin
      check_output("tbl_wr_addr", {13'b0, got_q[k][18:16]}, k);
      check_output("tbl_wr_data", {16'b0, got_q[k][15:0]}, {16'b0, v.w[k]});
    end
    if (got_q.size() > 0) begin
      check_output("tbl_last_addr", {13'b0, got_q[$][18:16]}, {29'b0, v.exp_last_addr});
      check_output("tbl_last_data", {16'b0, got_q[$][15:0]}, {16'b0, v.exp_last_data});
    end
    check_output("tbl_instr_count", {27'b0, instr_count}, {28'b0, v.exp_count});
    check_output("tbl_error", {31'b0, error}, {31'b0, v.exp_err});
    check_output("tbl_prog_done", {31'b0, prog_done}, {31'b0, v.exp_done});
    check_output("tbl_byte_ready", {31'b0, byte_ready}, 32'd0);
  endtask

  task automatic check_reset_outputs();
    check_output("rst_byte_ready", {31'b0, byte_ready}, 32'd0);
    check_output("rst_wr_en", {31'b0, wr_en}, 32'd0);
    check_output("rst_wr_addr", {29'b0, wr_addr}, 32'd0);
    check_output("rst_wr_data", {16'b0, wr_data}, 32'd0);
    check_output("rst_prog_done", {31'b0, prog_done}, 32'd0);
    check_output("rst_instr_count", {28'b0, instr_count}, 32'd0);
    check_output("rst_error", {31'b0, error}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tbl[0] = '0;
    tbl[0].n = 4'd3;
    tbl[0].w[0] = 16'h200F;
    tbl[0].w[1] = 16'h4000;
    tbl[0].w[2] = 16'h0000;
    tbl[0].exp_count = 4'd3;
    tbl[0].exp_done = 1'b1;
    tbl[0].exp_last_addr = 3'd2;
    tbl[0].exp_last_data = 16'h0000;

    tbl[1] = '0;
    tbl[1].n = 4'd8;
    for (int k = 0; k < 8; k++) tbl[1].w[k] = 16'h2001 + 16'(k);
    tbl[1].exp_count = 4'd8;
    tbl[1].exp_err = 1'b1;
    tbl[1].exp_done = 1'b1;
    tbl[1].exp_last_addr = 3'd7;
    tbl[1].exp_last_data = 16'h2008;

    tbl[2] = '0;
    tbl[2].n = 4'd1;
    tbl[2].w[0] = 16'h1FFF;
    tbl[2].exp_count = 4'd1;
    tbl[2].exp_done = 1'b1;
    tbl[2].exp_last_addr = 3'd0;
    tbl[2].exp_last_data = 16'h1FFF;

    tbl[3] = '0;
    tbl[3].n = 4'd8;
    for (int k = 0; k < 7; k++) tbl[3].w[k] = 16'hE000 + 16'(k);
    tbl[3].w[7] = 16'h0ABC;
    tbl[3].exp_count = 4'd8;
    tbl[3].exp_done = 1'b1;
    tbl[3].exp_last_addr = 3'd7;
    tbl[3].exp_last_data = 16'h0ABC;

    #2 reset = 1'b0;
    #10;
    check_reset_outputs();
    step();
    reset = 1'b1;

    // Out of reset, valid bytes must be ignored until a load is requested.
    byte_in = 8'hAA;
    byte_valid = 1'b1;
    repeat (4) step();
    check_output("idle_byte_ready", {31'b0, byte_ready}, 32'd0);
    check_output("idle_no_write", got_q.size(), 32'd0);
    check_output("idle_prog_done", {31'b0, prog_done}, 32'd0);
    byte_valid = 1'b0;

    max_gap = 0;
    for (int i = 0; i < 4; i++) run_vec(i);

    // Restart from DONE: status clears and writing begins again at address 0.
    start_load();
    check_output("restart_prog_done", {31'b0, prog_done}, 32'd0);
    check_output("restart_instr_count", {27'b0, instr_count}, 32'd0);
    check_output("restart_error", {31'b0, error}, 32'd0);
    prog_q.delete();
    prog_q.push_back(16'h0123);
    model_program();
    apply_stimulus();
    check_against_model();

    // Gap of 10 idle cycles before the low byte, with load_en held (ignored).
    start_load();
    send_byte(8'h60, 0);
    load_en = 1'b1;
    repeat (10) step();
    load_en = 1'b0;
    send_byte(8'h00, 0);
    check_output("gap_n_writes", got_q.size(), 32'd1);
    if (got_q.size() > 0) check_output("gap_wr_data", {13'b0, got_q[0]}, {13'b0, 3'd0, 16'h6000});
    check_output("gap_latency", last_wr_cyc, last_xfer_cyc + 1);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    step();
    step();
    check_output("gap_total_writes", got_q.size(), 32'd2);
    check_output("gap_prog_done", {31'b0, prog_done}, 32'd1);
    check_output("gap_error", {31'b0, error}, 32'd0);

    // Timeout after the high byte: still waiting after 254 idle cycles, aborted after 255.
    start_load();
    send_byte(8'h80, 0);
    repeat (254) step();
    check_output("to_error_early", {31'b0, error}, 32'd0);
    check_output("to_ready_early", {31'b0, byte_ready}, 32'd1);
    step();
    check_output("to_error", {31'b0, error}, 32'd1);
    check_output("to_ready", {31'b0, byte_ready}, 32'd0);
    check_output("to_prog_done", {31'b0, prog_done}, 32'd0);
    check_output("to_no_write", got_q.size(), 32'd0);

    // Reset in the middle of an instruction abandons it without a stray write.
    start_load();
    send_byte(8'h20, 0);
    step();
    reset = 1'b0;
    #1;
    check_reset_outputs();
    step();
    step();
    reset = 1'b1;
    byte_in = 8'h0F;
    byte_valid = 1'b1;
    repeat (3) step();
    byte_valid = 1'b0;
    check_output("midrst_no_write", got_q.size(), 32'd0);
    check_output("midrst_byte_ready", {31'b0, byte_ready}, 32'd0);
    run_vec(0);

    max_gap = 3;
    for (int r = 0; r < 25; r++) begin
      int len;
      len = $urandom_range(1, 9);
      prog_q.delete();
      for (int k = 0; k < len; k++) begin
        logic [2:0] op;
        op = (k == len - 1 && len <= DEPTH) ? 3'd0 : 3'($urandom_range(1, 7));
        prog_q.push_back({op, 13'($urandom)});
      end
      model_program();
      start_load();
      apply_stimulus();
      check_against_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
